ysyx_22051013_csr_file: RTL and testbench
=========================================

# ysyx_22051013_csr_file

Parametrised machine-mode CSR file for the pipelined core, sitting beside the execute stage. It supports the full CSRRW/CSRRS/CSRRC read-modify-write semantics and vectored trap dispatch. It adds interrupt sources (mie/mip with timer, software and external lines), free-running mcycle/minstret counters and illegal-access detection. Trap entry and mret update state in one cycle and issue a registered PC redirect to fetch.

## Interface
- XLEN, 64, data width of every CSR (32 or 64)
- HARTID, 0, value returned by mhartid
- VECTORED_EN, 1, 1: mtvec mode 1 (vectored) honoured; 0: mode hardwired to 0
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset (one clock; sync reset, high-active, fixed)
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1/uimm operand
- csr_rdata  out  XLEN  old CSR value, combinational
- csr_illegal  out  1  access to unimplemented or read-only CSR, combinational
- trap_req  in  1  take trap this cycle (exception or accepted interrupt)
- trap_cause  in  XLEN  mcause value to record (bit XLEN-1 = interrupt)
- trap_pc  in  XLEN  PC to save into mepc
- mret  in  1  mret retiring this cycle
- retire  in  1  one instruction retired this cycle
- irq_timer, irq_soft, irq_ext  in  1 each  level interrupt lines
- irq_req  out  1  enabled interrupt pending
- irq_cause  out  XLEN  cause to pass back on trap_cause
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  XLEN  redirect target

## Operation
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. RS/RC with wdata==0 perform no write.
- Field rules:
  - mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11 always; other bits read 0.
  - mie: only MSIE[3], MTIE[7], MEIE[11] writable.
  - mtvec[1] reads 0; mtvec[0] reads 0 when VECTORED_EN=0.
  - mepc[1:0] read 0.
  - mip: bits 3/7/11 = registered irq_soft/irq_timer/irq_ext.
- Read-only CSRs:
  - mip writes are ignored and are not illegal.
  - mhartid reads HARTID; any RW write to it, or an RS/RC write with nonzero wdata, is illegal.
- csr_illegal: unimplemented address with csr_op≠0, or an illegal mhartid write. No state changes when it is set; csr_rdata = 0.
- irq_req = MIE & |(mie & mip). irq_cause = {1, code}, priority MEI(11) > MSI(3) > MTI(7).
- Trap entry (trap_req):
  - mepc ← trap_pc & ~3; mcause ← trap_cause; MPIE ← MIE; MIE ← 0.
  - Target = mtvec base, plus 4×code when mode=1 and cause is an interrupt.
- mret: MIE ← MPIE; MPIE ← 1; target = mepc.
- mcycle increments every cycle. minstret increments when retire=1. A CSR write to either counter replaces that cycle's increment.

## Timing
- csr_rdata, csr_illegal, irq_req and irq_cause are combinational from current state. CSR writes land at the next posedge.
- mip lags the irq lines by 1 cycle.
- redirect_valid is registered, asserted exactly 1 cycle after trap_req or mret, for 1 cycle, with redirect_pc from the pre-update mtvec/mepc.
- Simultaneous events, highest priority first:
  - trap_req beats mret and csr_op: both are ignored.
  - mret beats csr_op: the CSR write is dropped.
- CSR write to mepc/mtvec in cycle N is visible to an mret/trap in cycle N+1.
- Reset values:
  - All CSRs 0, except mstatus MPP=11 and mhartid=HARTID.
  - redirect_valid=0, redirect_pc=0.
  - Reset mid-trap cancels a pending redirect.

## Structure
- Package ysyx_22051013_csr_pkg: CSR address constants, csr_op encodings, interrupt cause codes (3/7/11), mstatus bit positions.
- Sub-module ysyx_22051013_csr_counter (XLEN-wide, inc/wr/wdata), instantiated for mcycle and minstret.

## Test plan
- Reset, then read 0x300 -> 0x1800; 0xF14 -> HARTID; mcycle counts 1,2,3 on successive reads.
- RW mtvec=0x8000_0001, RS mie 0x80, RC mie 0x80 -> reads 0x8000_0001, 0x80, 0x00; csr_rdata returns old values.
- Exception: MIE=1, trap_req, cause=2, pc=0x8000_0106 -> next cycle redirect_valid=1, redirect_pc=mtvec base; mepc=0x8000_0104, MIE=0, MPIE=1.
- Vectored: mtvec=0x8000_0001, MIE=1, MTIE=1, irq_timer high -> irq_req 1 cycle later, irq_cause=0x8000…07. Trap -> redirect_pc=0x8000_001C. Then mret -> redirect_pc=mepc, MIE=1.
- Simultaneous: trap_req+mret+RW mscratch in one cycle -> only trap effects; mscratch unchanged. Write to 0x7C0 and to 0xF14 -> csr_illegal=1, no state change.
- Counter collision: RW mcycle=5 in cycle N -> reads 5 in N+1, 6 in N+2. retire with RW minstret=0 -> 0.

Source files
------------

// File: rtl/ysyx_22051013_csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings, field positions.
// No logic; imported by the interface, the top and the test bench.
package ysyx_22051013_csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    // Interrupt cause codes double as bit positions in mie/mip.
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/ysyx_22051013_csr_file_if.sv
// CSR access port plus trap/mret requests and the fetch redirect back to the core.
// Master is the execute stage; the CSR file is the slave and never stalls.
interface ysyx_22051013_csr_file_if
    import ysyx_22051013_csr_pkg::*;
#(
    parameter int XLEN = 64
);
    csr_op_e           csr_op;
    logic [11:0]       csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;
    logic              csr_illegal;
    logic              trap_req;
    logic [XLEN-1:0]   trap_cause;
    logic [XLEN-1:0]   trap_pc;
    logic              mret;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    modport master (
        output csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc, mret,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );

    modport slave (
        input  csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc, mret,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22051013_csr_counter.sv
// Free-running XLEN counter with a synchronous load that takes precedence over increment.
// Load/increment visible one cycle later; no backpressure.
module ysyx_22051013_csr_counter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            wr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] count
);
    logic [XLEN-1:0] count_q;
    logic [XLEN-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (wr) begin
            count_d = wdata;
        end else if (inc) begin
            count_d = count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/ysyx_22051013_csr_file.sv
// Machine-mode CSR file with interrupt gating, trap entry/mret and a registered fetch redirect.
// Reads/illegal/irq are combinational; writes land next edge; redirect 1 cycle after trap/mret; never stalls.
module ysyx_22051013_csr_file
    import ysyx_22051013_csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] HARTID      = '0,
    parameter bit              VECTORED_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22051013_csr_file_if.slave        bus,
    input  logic                           retire,
    input  logic                           irq_timer,
    input  logic                           irq_soft,
    input  logic                           irq_ext,
    output logic                           irq_req,
    output logic [XLEN-1:0]                irq_cause
);
    logic            mie_bit_q, mie_bit_d;
    logic            mpie_q, mpie_d;
    logic            msie_q, msie_d;
    logic            mtie_q, mtie_d;
    logic            meie_q, meie_d;
    logic            msip_q, mtip_q, meip_q;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [XLEN-1:0] mcycle, minstret;
    logic [XLEN-1:0] mtvec_rd, mepc_rd, rd_val, wval;
    logic [XLEN-1:0] trap_base, trap_code, trap_target;
    logic            hit, op_is_set, wdata_nz, hartid_bad, illegal, csr_we;
    logic            mcycle_wr, minstret_wr;
    logic [2:0]      pend;

    // mtvec[1] never reads back; mtvec[0] only survives when vectored mode is supported.
    assign mtvec_rd = mtvec_q & ~XLEN'(VECTORED_EN ? 2 : 3);
    assign mepc_rd  = mepc_q & ~XLEN'(3);

    always_comb begin
        rd_val = '0;
        hit    = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS: begin
                rd_val[MSTATUS_MIE]                   = mie_bit_q;
                rd_val[MSTATUS_MPIE]                  = mpie_q;
                rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            ADDR_MIE: begin
                rd_val[IRQ_MSI] = msie_q;
                rd_val[IRQ_MTI] = mtie_q;
                rd_val[IRQ_MEI] = meie_q;
            end
            ADDR_MIP: begin
                rd_val[IRQ_MSI] = msip_q;
                rd_val[IRQ_MTI] = mtip_q;
                rd_val[IRQ_MEI] = meip_q;
            end
            ADDR_MTVEC:    rd_val = mtvec_rd;
            ADDR_MSCRATCH: rd_val = mscratch_q;
            ADDR_MEPC:     rd_val = mepc_rd;
            ADDR_MCAUSE:   rd_val = mcause_q;
            ADDR_MCYCLE:   rd_val = mcycle;
            ADDR_MINSTRET: rd_val = minstret;
            ADDR_MHARTID:  rd_val = HARTID;
            default:       hit    = 1'b0;
        endcase
    end

    assign op_is_set  = (bus.csr_op == CSR_RS) || (bus.csr_op == CSR_RC);
    assign wdata_nz   = |bus.csr_wdata;
    assign hartid_bad = (bus.csr_addr == ADDR_MHARTID) &&
                        ((bus.csr_op == CSR_RW) || (op_is_set && wdata_nz));
    assign illegal    = ((bus.csr_op != CSR_NONE) && !hit) || hartid_bad;

    // Set/clear with a zero mask is a pure read; trap and mret both pre-empt the CSR op.
    assign csr_we = (bus.csr_op != CSR_NONE) && !illegal && !(op_is_set && !wdata_nz) &&
                    !bus.trap_req && !bus.mret;

    always_comb begin
        case (bus.csr_op)
            CSR_RW:  wval = bus.csr_wdata;
            CSR_RS:  wval = rd_val | bus.csr_wdata;
            CSR_RC:  wval = rd_val & ~bus.csr_wdata;
            default: wval = rd_val;
        endcase
    end

    assign bus.csr_rdata   = illegal ? '0 : rd_val;
    assign bus.csr_illegal = illegal;

    assign pend    = {meie_q & meip_q, msie_q & msip_q, mtie_q & mtip_q};
    assign irq_req = mie_bit_q & (|pend);

    always_comb begin
        irq_cause = '0;
        if (pend[2]) begin
            irq_cause = {1'b1, (XLEN-1)'(IRQ_MEI)};
        end else if (pend[1]) begin
            irq_cause = {1'b1, (XLEN-1)'(IRQ_MSI)};
        end else if (pend[0]) begin
            irq_cause = {1'b1, (XLEN-1)'(IRQ_MTI)};
        end
    end

    assign trap_base   = mtvec_rd & ~XLEN'(3);
    assign trap_code   = {1'b0, bus.trap_cause[XLEN-2:0]};
    assign trap_target = (mtvec_rd[0] && bus.trap_cause[XLEN-1]) ?
                         trap_base + (trap_code << 2) : trap_base;

    always_comb begin
        mie_bit_d        = mie_bit_q;
        mpie_d           = mpie_q;
        msie_d           = msie_q;
        mtie_d           = mtie_q;
        meie_d           = meie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        redirect_valid_d = bus.trap_req | bus.mret;
        redirect_pc_d    = redirect_pc_q;
        if (bus.trap_req) begin
            mepc_d        = bus.trap_pc & ~XLEN'(3);
            mcause_d      = bus.trap_cause;
            mpie_d        = mie_bit_q;
            mie_bit_d     = 1'b0;
            redirect_pc_d = trap_target;
        end else if (bus.mret) begin
            mie_bit_d     = mpie_q;
            mpie_d        = 1'b1;
            redirect_pc_d = mepc_rd;
        end else if (csr_we) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mie_bit_d = wval[MSTATUS_MIE];
                    mpie_d    = wval[MSTATUS_MPIE];
                end
                ADDR_MIE: begin
                    msie_d = wval[IRQ_MSI];
                    mtie_d = wval[IRQ_MTI];
                    meie_d = wval[IRQ_MEI];
                end
                ADDR_MTVEC:    mtvec_d    = wval;
                ADDR_MSCRATCH: mscratch_d = wval;
                ADDR_MEPC:     mepc_d     = wval & ~XLEN'(3);
                ADDR_MCAUSE:   mcause_d   = wval;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_bit_q        <= 1'b0;
            mpie_q           <= 1'b0;
            msie_q           <= 1'b0;
            mtie_q           <= 1'b0;
            meie_q           <= 1'b0;
            msip_q           <= 1'b0;
            mtip_q           <= 1'b0;
            meip_q           <= 1'b0;
            mtvec_q          <= '0;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mie_bit_q        <= mie_bit_d;
            mpie_q           <= mpie_d;
            msie_q           <= msie_d;
            mtie_q           <= mtie_d;
            meie_q           <= meie_d;
            msip_q           <= irq_soft;
            mtip_q           <= irq_timer;
            meip_q           <= irq_ext;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

    assign mcycle_wr   = csr_we && (bus.csr_addr == ADDR_MCYCLE);
    assign minstret_wr = csr_we && (bus.csr_addr == ADDR_MINSTRET);

    ysyx_22051013_csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr    (mcycle_wr),
        .wdata (wval),
        .count (mcycle)
    );

    ysyx_22051013_csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr    (minstret_wr),
        .wdata (wval),
        .count (minstret)
    );
endmodule

// File: tb/tb_ysyx_22051013_csr_file.sv
// Directed bench for the CSR file: inputs change 1 ns after posedge, outputs sampled at negedge.
module tb_ysyx_22051013_csr_file;
    import ysyx_22051013_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire, irq_timer, irq_soft, irq_ext, irq_req;
    logic [63:0] irq_cause;
    int          total = 0;
    int          bad   = 0;

    localparam logic [63:0] IRQ_BIT = 64'h8000_0000_0000_0000;

    ysyx_22051013_csr_file_if #(.XLEN(64)) bus ();

    ysyx_22051013_csr_file #(
        .XLEN        (64),
        .HARTID      (64'd5),
        .VECTORED_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .retire    (retire),
        .irq_timer (irq_timer),
        .irq_soft  (irq_soft),
        .irq_ext   (irq_ext),
        .irq_req   (irq_req),
        .irq_cause (irq_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.csr_op     = CSR_NONE;
        bus.csr_addr   = 12'h000;
        bus.csr_wdata  = '0;
        bus.trap_req   = 1'b0;
        bus.trap_cause = '0;
        bus.trap_pc    = '0;
        bus.mret       = 1'b0;
        retire         = 1'b0;
    endtask

    task automatic drv(input csr_op_e op, input logic [11:0] a, input logic [63:0] d);
        bus.csr_op    = op;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [11:0] a);
        drv(CSR_RS, a, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        irq_timer = 1'b0; irq_soft = 1'b0; irq_ext = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and free-running mcycle
        rd(ADDR_MCYCLE);
        @(negedge clk);
        chk("mcycle_0", bus.csr_rdata, 64'd0);
        chk("rst_redir_vld", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst_redir_pc", bus.redirect_pc, 64'd0);
        chk("rst_irq_req", {63'd0, irq_req}, 64'd0);
        for (int i = 1; i <= 3; i++) begin
            nxt(); rd(ADDR_MCYCLE); @(negedge clk);
            chk("mcycle_cnt", bus.csr_rdata, 64'(i));
        end
        nxt(); rd(ADDR_MSTATUS); @(negedge clk);
        chk("rst_mstatus", bus.csr_rdata, 64'h1800);
        nxt(); rd(ADDR_MHARTID); @(negedge clk);
        chk("mhartid", bus.csr_rdata, 64'd5);
        chk("mhartid_read_legal", {63'd0, bus.csr_illegal}, 64'd0);

        // RW/RS/RC semantics, old value returned
        nxt(); drv(CSR_RW, ADDR_MTVEC, 64'h8000_0001); @(negedge clk);
        chk("mtvec_rw_old", bus.csr_rdata, 64'd0);
        nxt(); drv(CSR_RS, ADDR_MIE, 64'h80); @(negedge clk);
        chk("mie_rs_old", bus.csr_rdata, 64'd0);
        nxt(); drv(CSR_RC, ADDR_MIE, 64'h80); @(negedge clk);
        chk("mie_rc_old", bus.csr_rdata, 64'h80);
        nxt(); rd(ADDR_MIE); @(negedge clk);
        chk("mie_after_rc", bus.csr_rdata, 64'h0);
        nxt(); rd(ADDR_MTVEC); @(negedge clk);
        chk("mtvec_rd", bus.csr_rdata, 64'h8000_0001);

        // Synchronous exception
        nxt(); drv(CSR_RS, ADDR_MSTATUS, 64'h8); @(negedge clk);
        chk("mstatus_set_old", bus.csr_rdata, 64'h1800);
        nxt();
        bus.trap_req = 1'b1; bus.trap_cause = 64'd2; bus.trap_pc = 64'h8000_0106;
        @(negedge clk);
        chk("exc_no_early_redir", {63'd0, bus.redirect_valid}, 64'd0);
        nxt(); rd(ADDR_MEPC); @(negedge clk);
        chk("exc_redir_vld", {63'd0, bus.redirect_valid}, 64'd1);
        chk("exc_redir_pc", bus.redirect_pc, 64'h8000_0000);
        chk("exc_mepc", bus.csr_rdata, 64'h8000_0104);
        nxt(); rd(ADDR_MSTATUS); @(negedge clk);
        chk("exc_redir_pulse", {63'd0, bus.redirect_valid}, 64'd0);
        chk("exc_mstatus", bus.csr_rdata, 64'h1880);
        nxt(); rd(ADDR_MCAUSE); @(negedge clk);
        chk("exc_mcause", bus.csr_rdata, 64'd2);

        // Vectored timer interrupt, then mret
        nxt(); drv(CSR_RS, ADDR_MSTATUS, 64'h8); @(negedge clk);
        chk("mstatus_set2_old", bus.csr_rdata, 64'h1880);
        nxt(); drv(CSR_RS, ADDR_MIE, 64'h80); irq_timer = 1'b1; @(negedge clk);
        chk("tmr_irq_lag", {63'd0, irq_req}, 64'd0);
        nxt(); @(negedge clk);
        chk("tmr_irq_req", {63'd0, irq_req}, 64'd1);
        chk("tmr_irq_cause", irq_cause, IRQ_BIT | 64'd7);
        bus.trap_req = 1'b1; bus.trap_cause = IRQ_BIT | 64'd7; bus.trap_pc = 64'h8000_0200;
        nxt(); rd(ADDR_MSTATUS); @(negedge clk);
        chk("vec_redir_vld", {63'd0, bus.redirect_valid}, 64'd1);
        chk("vec_redir_pc", bus.redirect_pc, 64'h8000_001C);
        chk("vec_irq_masked", {63'd0, irq_req}, 64'd0);
        chk("vec_mstatus", bus.csr_rdata, 64'h1880);
        nxt(); bus.mret = 1'b1; irq_timer = 1'b0; @(negedge clk);
        nxt(); rd(ADDR_MSTATUS); @(negedge clk);
        chk("mret_redir_vld", {63'd0, bus.redirect_valid}, 64'd1);
        chk("mret_redir_pc", bus.redirect_pc, 64'h8000_0200);
        chk("mret_mstatus", bus.csr_rdata, 64'h1888);

        // Interrupt priority and read-only mip
        nxt(); drv(CSR_RS, ADDR_MIE, 64'h888); irq_soft = 1'b1; irq_timer = 1'b1; @(negedge clk);
        chk("mie_all_old", bus.csr_rdata, 64'h80);
        nxt(); rd(ADDR_MIP); irq_ext = 1'b1; @(negedge clk);
        chk("prio_msi_over_mti", irq_cause, IRQ_BIT | 64'd3);
        chk("mip_soft_timer", bus.csr_rdata, 64'h88);
        nxt(); drv(CSR_RW, ADDR_MIP, 64'd0); @(negedge clk);
        chk("prio_mei_first", irq_cause, IRQ_BIT | 64'd11);
        chk("mip_wr_legal", {63'd0, bus.csr_illegal}, 64'd0);
        nxt(); rd(ADDR_MIP); irq_soft = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; @(negedge clk);
        chk("mip_wr_ignored", bus.csr_rdata, 64'h888);
        nxt(); drv(CSR_RC, ADDR_MSTATUS, 64'h8); @(negedge clk);
        chk("mip_cleared_irq", {63'd0, irq_req}, 64'd0);

        // trap beats mret and CSR write; mret beats CSR write
        nxt(); drv(CSR_RW, ADDR_MSCRATCH, 64'h1234); @(negedge clk);
        nxt(); drv(CSR_RW, ADDR_MSCRATCH, 64'hDEAD);
        bus.trap_req = 1'b1; bus.trap_cause = 64'd2; bus.trap_pc = 64'h8000_0300; bus.mret = 1'b1;
        @(negedge clk);
        nxt(); rd(ADDR_MSCRATCH); @(negedge clk);
        chk("simul_redir_pc", bus.redirect_pc, 64'h8000_0000);
        chk("simul_mscratch", bus.csr_rdata, 64'h1234);
        nxt(); rd(ADDR_MSTATUS); @(negedge clk);
        chk("simul_mstatus", bus.csr_rdata, 64'h1800);
        nxt(); drv(CSR_RW, ADDR_MSCRATCH, 64'h55); bus.mret = 1'b1; @(negedge clk);
        nxt(); rd(ADDR_MSCRATCH); @(negedge clk);
        chk("mret_beats_csr_pc", bus.redirect_pc, 64'h8000_0300);
        chk("mret_beats_csr", bus.csr_rdata, 64'h1234);

        // Illegal accesses
        nxt(); drv(CSR_RW, 12'h7C0, 64'hFF); @(negedge clk);
        chk("unimpl_illegal", {63'd0, bus.csr_illegal}, 64'd1);
        chk("unimpl_rdata", bus.csr_rdata, 64'd0);
        nxt(); drv(CSR_RW, ADDR_MHARTID, 64'd0); @(negedge clk);
        chk("hartid_rw_illegal", {63'd0, bus.csr_illegal}, 64'd1);
        nxt(); drv(CSR_RS, ADDR_MHARTID, 64'd1); @(negedge clk);
        chk("hartid_rs_illegal", {63'd0, bus.csr_illegal}, 64'd1);
        nxt(); drv(CSR_NONE, 12'h7C0, 64'd0); @(negedge clk);
        chk("unimpl_no_op_legal", {63'd0, bus.csr_illegal}, 64'd0);
        nxt(); rd(ADDR_MHARTID); @(negedge clk);
        chk("hartid_unchanged", bus.csr_rdata, 64'd5);

        // mepc write visible to mret on the next cycle
        nxt(); drv(CSR_RW, ADDR_MEPC, 64'h8000_0403); @(negedge clk);
        nxt(); bus.mret = 1'b1; @(negedge clk);
        nxt(); @(negedge clk);
        chk("mepc_fwd_redir", bus.redirect_pc, 64'h8000_0400);

        // Counter write collisions
        nxt(); drv(CSR_RW, ADDR_MCYCLE, 64'd5); @(negedge clk);
        nxt(); rd(ADDR_MCYCLE); @(negedge clk);
        chk("mcycle_wr", bus.csr_rdata, 64'd5);
        nxt(); rd(ADDR_MCYCLE); @(negedge clk);
        chk("mcycle_wr_inc", bus.csr_rdata, 64'd6);
        for (int i = 0; i < 2; i++) begin
            nxt(); rd(ADDR_MINSTRET); retire = 1'b1; @(negedge clk);
            chk("minstret_cnt", bus.csr_rdata, 64'(i));
        end
        nxt(); drv(CSR_RW, ADDR_MINSTRET, 64'd0); retire = 1'b1; @(negedge clk);
        chk("minstret_old", bus.csr_rdata, 64'd2);
        nxt(); rd(ADDR_MINSTRET); @(negedge clk);
        chk("minstret_wr_wins", bus.csr_rdata, 64'd0);

        // Reset while a trap is requested
        nxt(); drv(CSR_RS, ADDR_MSTATUS, 64'h8); @(negedge clk);
        nxt(); rst = 1'b1;
        bus.trap_req = 1'b1; bus.trap_cause = 64'd2; bus.trap_pc = 64'h8000_0500;
        @(negedge clk);
        nxt(); rst = 1'b0; rd(ADDR_MEPC); @(negedge clk);
        chk("rst_trap_no_redir", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst_trap_pc", bus.redirect_pc, 64'd0);
        chk("rst_trap_mepc", bus.csr_rdata, 64'd0);
        nxt(); rd(ADDR_MSTATUS); @(negedge clk);
        chk("rst_trap_mstatus", bus.csr_rdata, 64'h1800);

        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
